fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Parametrised instruction fetch stage; successor to the single-register PC fetcher.
//   Issues word-aligned requests to instruction memory over a valid/ready handshake and
//   tolerates any in-order response latency of 1 cycle or more.
//   Buffers {pc, instr} pairs in a prefetch FIFO and presents them to decode via valid/ready.
//   Handles control-flow redirects by flushing the FIFO and discarding in-flight responses.
// PARAMETERS
//   XLEN          32            address/PC width
//   RESET_VECTOR  32'h0000_0000 PC after reset (bits[1:0] must be 0)
//   FIFO_DEPTH    4             prefetch entries; power of 2, >= 2; also the max in-flight requests
// PORTS
//   clk              in   1     clock, all state updates on posedge
//   rst              in   1     synchronous reset, active-high
//   redirect_valid   in   1     jump/branch taken this cycle
//   redirect_target  in   XLEN  new PC; bits[1:0] ignored (forced 0)
//   imem_req_valid   out  1     fetch request offered
//   imem_req_ready   in   1     memory accepts request
//   imem_req_addr    out  XLEN  request address (= fetch_pc)
//   imem_rsp_valid   in   1     one response word, strictly in request order
//   imem_rsp_data    in   32    instruction word
//   dec_valid        out  1     FIFO head valid
//   dec_ready        in   1     decode consumes head
//   dec_instr        out  32    head instruction
//   dec_pc           out  XLEN  head PC
// BEHAVIOUR
//   Reset (rst=1 at posedge): fetch_pc=rsp_pc=RESET_VECTOR; FIFO count, outstanding, drop_cnt=0.
//     Outputs: imem_req_valid=0, dec_valid=0, dec_instr=0, dec_pc=0.
//     Mid-operation reset discards everything; imem is reset alongside, so no stale responses.
//   Request: imem_req_valid = !rst && !redirect_valid && (outstanding + count < FIFO_DEPTH).
//     Uses registered values only; the credit scheme guarantees every response has a FIFO slot.
//     Transfer occurs only when valid && ready; valid may drop without a handshake (no stability rule).
//     On transfer: fetch_pc += 4 (wraps modulo 2^XLEN); outstanding += 1.
//   Response: each imem_rsp_valid decrements outstanding.
//     If drop_cnt != 0: discard the response and decrement drop_cnt.
//     Else: push {rsp_pc, imem_rsp_data}; rsp_pc += 4 (wraps).
//     Request transfer and response in the same cycle: outstanding unchanged.
//   Decode: dec_valid = (count != 0); head is registered, so a response at cycle M is visible at M+1.
//     Pop on dec_valid && dec_ready; push and pop in the same cycle leaves count unchanged (legal when full).
//   Redirect (cycle R): FIFO flushed (count=0, dec_valid=0 at R+1); any pop at R is ignored.
//     fetch_pc = rsp_pc = {target[XLEN-1:2],2'b00}.
//     drop_cnt = outstanding - (imem_rsp_valid at R ? 1 : 0); a response at R is itself dropped.
//     No request issued at R; a request for the target may issue at R+1.
//     Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
//   Widths: outstanding, count and drop_cnt are $clog2(FIFO_DEPTH)+1 bits; none can exceed FIFO_DEPTH.
// TESTING
//   1. Release rst, imem ready=1, latency 1 -> addrs 0x0,0x4,0x8...; dec_pc follows; dec_valid from cycle 3.
//   2. dec_ready=0, latency 1 -> exactly 4 requests, FIFO full, imem_req_valid=0 until first pop.
//   3. Latency 3, 3 in flight, redirect to 0x103 -> the 3 responses are dropped.
//      First dec_pc=0x100 carries the data for addr 0x100.
//   4. Redirect in the same cycle as a response and dec_ready -> FIFO empty next cycle; no stray entry.
//   5. redirect_target=32'hFFFF_FFFC -> requests 0xFFFFFFFC then 0x00000000 (wrap).
//   6. Assert rst mid-stream with a full FIFO -> all outputs 0 next cycle; restart at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited request issue, in-order response capture into a
// prefetch FIFO of {pc, instr}, and redirect handling that flushes and drops in-flight words.
module fetch_unit #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              FIFO_DEPTH   = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [31:0]     dec_instr,
   output logic [XLEN-1:0] dec_pc
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
   logic [XLEN-1:0] rsp_pc_reg, rsp_pc_next;
   logic [CW-1:0]   outstanding_reg, outstanding_next;
   logic [CW-1:0]   count_reg, count_next;
   logic [CW-1:0]   drop_cnt_reg, drop_cnt_next;
   logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;

   logic [31:0]     instr_mem [FIFO_DEPTH];
   logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];

   logic [CW:0]     credit_used;
   logic [XLEN-1:0] target_aligned;
   logic            req_fire;
   logic            push;
   logic            pop;

   // Slots promised to in-flight requests count as used, so every response finds room.
   assign credit_used    = {1'b0, outstanding_reg} + {1'b0, count_reg};
   assign imem_req_valid = !rst && !redirect_valid && (credit_used < (CW+1)'(FIFO_DEPTH));
   assign imem_req_addr  = fetch_pc_reg;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign target_aligned = redirect_target & ~XLEN'(3);

   assign dec_valid = (count_reg != '0);
   assign dec_instr = dec_valid ? instr_mem[rd_ptr_reg] : '0;
   assign dec_pc    = dec_valid ? pc_mem[rd_ptr_reg]    : '0;

   assign push = imem_rsp_valid && (drop_cnt_reg == '0) && !redirect_valid;
   assign pop  = dec_valid && dec_ready && !redirect_valid;

   always_comb begin
      fetch_pc_next    = fetch_pc_reg;
      rsp_pc_next      = rsp_pc_reg;
      count_next       = count_reg;
      drop_cnt_next    = drop_cnt_reg;
      wr_ptr_next      = wr_ptr_reg;
      rd_ptr_next      = rd_ptr_reg;
      outstanding_next = outstanding_reg + CW'(req_fire) - CW'(imem_rsp_valid);

      if (redirect_valid) begin
         fetch_pc_next = target_aligned;
         rsp_pc_next   = target_aligned;
         count_next    = '0;
         wr_ptr_next   = '0;
         rd_ptr_next   = '0;
         // A response arriving in the redirect cycle is already discarded, so it is not counted.
         drop_cnt_next = outstanding_reg - CW'(imem_rsp_valid);
      end else begin
         if (req_fire) begin
            fetch_pc_next = fetch_pc_reg + XLEN'(4);
         end
         if (imem_rsp_valid && (drop_cnt_reg != '0)) begin
            drop_cnt_next = drop_cnt_reg - CW'(1);
         end
         if (push) begin
            rsp_pc_next = rsp_pc_reg + XLEN'(4);
            wr_ptr_next = wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
         end
         count_next = count_reg + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_reg    <= RESET_VECTOR;
         rsp_pc_reg      <= RESET_VECTOR;
         outstanding_reg <= '0;
         count_reg       <= '0;
         drop_cnt_reg    <= '0;
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
      end else begin
         fetch_pc_reg    <= fetch_pc_next;
         rsp_pc_reg      <= rsp_pc_next;
         outstanding_reg <= outstanding_next;
         count_reg       <= count_next;
         drop_cnt_reg    <= drop_cnt_next;
         wr_ptr_reg      <= wr_ptr_next;
         rd_ptr_reg      <= rd_ptr_next;
      end
   end

   // Storage has no reset; outputs are masked by dec_valid while entries are stale.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         instr_mem[wr_ptr_reg] <= imem_rsp_data;
         pc_mem[wr_ptr_reg]    <= rsp_pc_reg;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an in-order instruction memory with per-request latency and a
// program-order model of the expected request and decode streams.
module tb_fetch_unit;
   localparam int          XLEN  = 32;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RV    = 32'h0000_0000;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        dec_valid;
   logic        dec_ready = 1'b0;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;

   fetch_unit #(.XLEN(XLEN), .RESET_VECTOR(RV), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_instr(dec_instr), .dec_pc(dec_pc)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int lat_min = 1;
   int lat_max = 1;
   int last_due = 0;

   logic [31:0] q_addr[$];
   int          q_due[$];
   logic [31:0] exp_req = RV;
   logic [31:0] exp_dec = RV;

   logic        o_req_valid, o_fire, o_dvalid, o_pop, o_rsp;
   logic [31:0] o_addr, o_pc, o_instr, x_req, x_dec;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
   endfunction

   // One clock: memory drives its response, outputs are sampled mid-cycle, then the model advances.
   task automatic cycle();
      int lat;
      int due;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (!rst && q_due.size() > 0 && q_due[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(q_addr[0]);
      end
      #2;
      o_req_valid = imem_req_valid;
      o_fire      = imem_req_valid && imem_req_ready;
      o_addr      = imem_req_addr;
      o_dvalid    = dec_valid;
      o_pop       = dec_valid && dec_ready && !redirect_valid && !rst;
      o_pc        = dec_pc;
      o_instr     = dec_instr;
      o_rsp       = imem_rsp_valid;
      x_req       = exp_req;
      x_dec       = exp_dec;
      @(posedge clk);
      #1;
      if (rst) begin
         q_addr.delete();
         q_due.delete();
         exp_req = RV;
         exp_dec = RV;
      end else begin
         if (o_rsp) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
         end
         if (o_fire) begin
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            q_addr.push_back(o_addr);
            q_due.push_back(due);
            last_due = due;
         end
         if (redirect_valid) begin
            exp_req = redirect_target & ~32'd3;
            exp_dec = redirect_target & ~32'd3;
         end else begin
            if (o_fire) exp_req = exp_req + 32'd4;
            if (o_pop)  exp_dec = exp_dec + 32'd4;
         end
      end
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cycle();
      cycle();
      vectors++;
      if (o_req_valid !== 1'b0 || o_dvalid !== 1'b0 || o_pc !== 32'h0 || o_instr !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: req_valid=%b dec_valid=%b dec_pc=%h dec_instr=%h, required all 0",
                  o_req_valid, o_dvalid, o_pc, o_instr);
      end
      rst = 1'b0;
   endtask

   task automatic test_stream();
      do_reset();
      imem_req_ready = 1'b1; dec_ready = 1'b1; lat_min = 1; lat_max = 1;
      for (int i = 0; i < 24; i++) begin
         cycle();
         if (i <= 2) begin
            vectors++;
            if (o_dvalid !== (i == 2)) begin
               miscompares++;
               $display("FAIL stream_dec_valid_start: cycle %0d dec_valid=%b required %b", i, o_dvalid, (i == 2));
            end
         end
         if (o_fire) begin
            vectors++;
            if (o_addr !== x_req) begin
               miscompares++;
               $display("FAIL stream_req_addr: got %h required %h", o_addr, x_req);
            end
         end
         if (o_pop) begin
            vectors++;
            if (o_pc !== x_dec || o_instr !== mem_word(x_dec)) begin
               miscompares++;
               $display("FAIL stream_dec: pc=%h instr=%h required pc=%h instr=%h", o_pc, o_instr, x_dec, mem_word(x_dec));
            end
         end
      end
   endtask

   task automatic test_full();
      int fires;
      do_reset();
      imem_req_ready = 1'b1; dec_ready = 1'b0; lat_min = 1; lat_max = 1;
      fires = 0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (o_fire) fires++;
      end
      vectors++;
      if (fires != DEPTH || o_req_valid !== 1'b0 || o_dvalid !== 1'b1) begin
         miscompares++;
         $display("FAIL full_stall: requests=%0d req_valid=%b dec_valid=%b, required %0d,0,1", fires, o_req_valid, o_dvalid, DEPTH);
      end
      dec_ready = 1'b1;
      cycle();
      vectors++;
      if (o_pop !== 1'b1 || o_req_valid !== 1'b0 || o_pc !== 32'h0 || o_instr !== mem_word(32'h0)) begin
         miscompares++;
         $display("FAIL full_first_pop: pop=%b req_valid=%b pc=%h instr=%h, required 1,0,00000000,%h",
                  o_pop, o_req_valid, o_pc, o_instr, mem_word(32'h0));
      end
      dec_ready = 1'b0;
      cycle();
      vectors++;
      if (o_req_valid !== 1'b1 || o_addr !== 32'h10) begin
         miscompares++;
         $display("FAIL full_resume: req_valid=%b addr=%h, required 1,00000010", o_req_valid, o_addr);
      end
   endtask

   task automatic test_redirect_drop();
      int  fires;
      bit  seen;
      do_reset();
      imem_req_ready = 1'b1; dec_ready = 1'b0; lat_min = 3; lat_max = 3;
      fires = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         if (o_fire) fires++;
      end
      vectors++;
      if (fires != 3) begin
         miscompares++;
         $display("FAIL drop_setup_requests: got %0d required 3", fires);
      end
      redirect_valid = 1'b1; redirect_target = 32'h0000_0103;
      cycle();
      vectors++;
      if (o_req_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL drop_no_req_on_redirect: req_valid=%b required 0", o_req_valid);
      end
      redirect_valid = 1'b0; dec_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (o_fire) begin
            vectors++;
            if (o_addr !== x_req) begin
               miscompares++;
               $display("FAIL drop_req_addr: got %h required %h", o_addr, x_req);
            end
         end
         if (o_pop) begin
            vectors++;
            if (o_pc !== x_dec || o_instr !== mem_word(x_dec)) begin
               miscompares++;
               $display("FAIL drop_dec: pc=%h instr=%h required pc=%h instr=%h", o_pc, o_instr, x_dec, mem_word(x_dec));
            end
            if (!seen) begin
               seen = 1'b1;
               vectors++;
               if (o_pc !== 32'h100) begin
                  miscompares++;
                  $display("FAIL drop_first_pc: got %h required 00000100", o_pc);
               end
            end
         end
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL drop_timeout: dec_valid seen=0 required 1 within 20 cycles");
      end
   endtask

   task automatic test_redirect_same_cycle();
      do_reset();
      imem_req_ready = 1'b1; dec_ready = 1'b1; lat_min = 1; lat_max = 1;
      repeat (6) cycle();
      redirect_valid = 1'b1; redirect_target = 32'h0000_2000;
      cycle();
      redirect_valid = 1'b0;
      cycle();
      vectors++;
      if (o_dvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL same_cycle_flush: dec_valid=%b required 0", o_dvalid);
      end
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (o_pop) begin
            vectors++;
            if (o_pc !== x_dec || o_instr !== mem_word(x_dec)) begin
               miscompares++;
               $display("FAIL same_cycle_dec: pc=%h instr=%h required pc=%h instr=%h", o_pc, o_instr, x_dec, mem_word(x_dec));
            end
         end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] got[$];
      do_reset();
      imem_req_ready = 1'b1; dec_ready = 1'b1; lat_min = 1; lat_max = 2;
      repeat (3) cycle();
      redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFE;
      cycle();
      redirect_valid = 1'b0;
      for (int i = 0; i < 10 && got.size() < 2; i++) begin
         cycle();
         if (o_fire) got.push_back(o_addr);
      end
      vectors++;
      if (got.size() < 2) begin
         miscompares++;
         $display("FAIL wrap_timeout: requests=%0d required 2 within 10 cycles", got.size());
      end else if (got[0] !== 32'hFFFF_FFFC || got[1] !== 32'h0000_0000) begin
         miscompares++;
         $display("FAIL wrap_addrs: got %h,%h required fffffffc,00000000", got[0], got[1]);
      end
   endtask

   task automatic test_mid_reset();
      bit found;
      do_reset();
      imem_req_ready = 1'b1; dec_ready = 1'b0; lat_min = 1; lat_max = 1;
      repeat (8) cycle();
      vectors++;
      if (o_dvalid !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_setup: dec_valid=%b required 1", o_dvalid);
      end
      rst = 1'b1;
      cycle();
      cycle();
      vectors++;
      if (o_req_valid !== 1'b0 || o_dvalid !== 1'b0 || o_pc !== 32'h0 || o_instr !== 32'h0) begin
         miscompares++;
         $display("FAIL midrst_outputs: req_valid=%b dec_valid=%b pc=%h instr=%h, required all 0",
                  o_req_valid, o_dvalid, o_pc, o_instr);
      end
      rst = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 5 && !found; i++) begin
         cycle();
         if (o_fire) begin
            found = 1'b1;
            vectors++;
            if (o_addr !== RV) begin
               miscompares++;
               $display("FAIL midrst_restart: addr=%h required %h", o_addr, RV);
            end
         end
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("FAIL midrst_timeout: no request within 5 cycles after reset");
      end
   endtask

   task automatic test_random();
      do_reset();
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 3000; i++) begin
         imem_req_ready = ($urandom_range(3, 0) != 0);
         dec_ready      = ($urandom_range(9, 0) < 6);
         redirect_valid = ($urandom_range(99, 0) < 3);
         redirect_target = $urandom;
         cycle();
         if (redirect_valid && o_req_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL rand_req_during_redirect: req_valid=%b required 0", o_req_valid);
         end
         if (o_fire) begin
            vectors++;
            if (o_addr !== x_req || q_addr.size() > DEPTH) begin
               miscompares++;
               $display("FAIL rand_req: addr=%h inflight=%0d required addr=%h inflight<=%0d", o_addr, q_addr.size(), x_req, DEPTH);
            end
         end
         if (o_pop) begin
            vectors++;
            if (o_pc !== x_dec || o_instr !== mem_word(x_dec)) begin
               miscompares++;
               $display("FAIL rand_dec: pc=%h instr=%h required pc=%h instr=%h", o_pc, o_instr, x_dec, mem_word(x_dec));
            end
         end
      end
      redirect_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_redirect_drop();
      test_redirect_same_cycle();
      test_wrap();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
